// File: rtl/pc_unit.sv
// Program-counter unit: increment, absolute load, relative branch with page fix-up, return stack.
// Latency: 1 cycle per command; a page-crossing BRANCH takes 2 cycles (IDLE -> FIXUP -> IDLE).
// Backpressure: i_ce low freezes all state; commands presented during FIXUP are ignored (o_busy high).
module pc_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int PAGE_BITS   = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'hFFFC
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [2:0]            i_cmd,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [PAGE_BITS-1:0]  i_offset,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_busy,
  output logic                  o_page_cross,
  output logic                  o_stack_full,
  output logic                  o_stack_empty,
  output logic                  o_stack_err
);

  localparam int HI_BITS = ADDR_WIDTH - PAGE_BITS;
  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [2:0] CMD_HOLD   = 3'd0;
  localparam logic [2:0] CMD_INC    = 3'd1;
  localparam logic [2:0] CMD_LOAD   = 3'd2;
  localparam logic [2:0] CMD_BRANCH = 3'd3;
  localparam logic [2:0] CMD_CALL   = 3'd4;
  localparam logic [2:0] CMD_RET    = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = 1;
  localparam logic [HI_BITS-1:0]    HI_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STACK_DEPTH);

  typedef enum logic {IDLE, FIXUP} state_t;

  state_t                  state;
  logic                    fix_fwd;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   stack_mem [STACK_DEPTH];

  logic [HI_BITS-1:0]      pch;
  logic [PAGE_BITS-1:0]    pcl;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [PAGE_BITS:0]      br_sum;
  logic [CNT_W-1:0]        cnt_m1;
  logic [PTR_W-1:0]        push_idx;
  logic [PTR_W-1:0]        pop_idx;

  // PC field split, increment, branch sum and stack pointers derived from registered state.
  always_comb begin
    pch      = o_pc[ADDR_WIDTH-1:PAGE_BITS];
    pcl      = o_pc[PAGE_BITS-1:0];
    pc_inc   = o_pc + PC_ONE;
    // In-page PCL zero-extended plus sign-extended offset; bit PAGE_BITS set means the
    // result left the current page (overflow for forward, underflow for backward).
    br_sum   = {1'b0, pcl} + {i_offset[PAGE_BITS-1], i_offset};
    cnt_m1   = cnt - CNT_ONE;
    push_idx = cnt[PTR_W-1:0];
    pop_idx  = cnt_m1[PTR_W-1:0];
  end

  assign o_stack_full  = (cnt == CNT_MAX);
  assign o_stack_empty = (cnt == '0);

  // Control FSM, PC register, stack count and one-cycle status pulses (phi2: falling edge).
  always_ff @(negedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      fix_fwd      <= 1'b0;
      o_pc         <= RESET_PC;
      o_busy       <= 1'b0;
      o_page_cross <= 1'b0;
      o_stack_err  <= 1'b0;
      cnt          <= '0;
    end else if (i_ce) begin
      o_page_cross <= 1'b0;
      o_stack_err  <= 1'b0;
      if (state == FIXUP) begin
        // Second branch cycle: only PCH moves; the command input is ignored.
        o_pc[ADDR_WIDTH-1:PAGE_BITS] <= fix_fwd ? (pch + HI_ONE) : (pch - HI_ONE);
        state  <= IDLE;
        o_busy <= 1'b0;
      end else begin
        case (i_cmd)
          CMD_HOLD: ;
          CMD_INC:  o_pc <= pc_inc;
          CMD_LOAD: o_pc <= i_addr;
          CMD_BRANCH: begin
            o_pc[PAGE_BITS-1:0] <= br_sum[PAGE_BITS-1:0];
            if (br_sum[PAGE_BITS]) begin
              state        <= FIXUP;
              o_busy       <= 1'b1;
              o_page_cross <= 1'b1;
              fix_fwd      <= ~i_offset[PAGE_BITS-1];
            end
          end
          CMD_CALL: begin
            o_pc <= i_addr;
            if (o_stack_full) o_stack_err <= 1'b1;
            else              cnt         <= cnt + CNT_ONE;
          end
          CMD_RET: begin
            if (o_stack_empty) begin
              o_stack_err <= 1'b1;
            end else begin
              o_pc <= stack_mem[pop_idx];
              cnt  <= cnt_m1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Return-address storage; contents need no reset since the count gates every read.
  always_ff @(negedge i_clk) begin
    if (i_reset_n && i_ce && state == IDLE && i_cmd == CMD_CALL && !o_stack_full)
      stack_mem[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [2:0]  cmd;
  logic [15:0] addr;
  logic [7:0]  off;
  logic [15:0] pc;
  logic        busy, pcross, full, empty, err;

  int total = 0;
  int bad   = 0;

  // Behavioural reference state
  logic [15:0] m_pc, m_fix;
  bit          m_busy, m_px, m_err;
  logic [15:0] m_stk[$];

  pc_unit dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_cmd(cmd), .i_addr(addr),
    .i_offset(off), .o_pc(pc), .o_busy(busy), .o_page_cross(pcross),
    .o_stack_full(full), .o_stack_empty(empty), .o_stack_err(err)
  );

  always #5 clk = ~clk;

  // Apply one set of inputs across one falling edge, then settle.
  task automatic cyc(input logic [2:0] c, input logic [15:0] a, input logic [7:0] o,
                     input logic e, input logic r);
    cmd = c; addr = a; off = o; ce = e; rst_n = r;
    @(negedge clk);
    #1;
  endtask

  // Reference model: whole-address arithmetic and a queue for the return stack.
  task automatic model_step(input logic [2:0] c, input logic [15:0] a, input logic [7:0] o,
                            input logic e, input logic r);
    logic [15:0] tgt;
    if (!r) begin
      m_pc = 16'hFFFC; m_busy = 0; m_px = 0; m_err = 0; m_stk.delete();
    end else if (e) begin
      m_px = 0; m_err = 0;
      if (m_busy) begin
        m_pc = m_fix; m_busy = 0;
      end else begin
        case (c)
          3'd1: m_pc = m_pc + 16'd1;
          3'd2: m_pc = a;
          3'd3: begin
            tgt = m_pc + {{8{o[7]}}, o};
            if (tgt[15:8] != m_pc[15:8]) begin
              m_pc = {m_pc[15:8], tgt[7:0]}; m_fix = tgt; m_busy = 1; m_px = 1;
            end else m_pc = tgt;
          end
          3'd4: begin
            if (m_stk.size() < 4) m_stk.push_back(m_pc + 16'd1); else m_err = 1;
            m_pc = a;
          end
          3'd5: begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back(); else m_err = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset;
    cyc(3'd0, 16'h0, 8'h0, 1'b0, 1'b0);
    total++; if (pc !== 16'hFFFC) begin bad++; $display("FAIL reset_pc got=%h exp=fffc", pc); end
    total++; if ({busy, pcross, err, full, empty} !== 5'b00001) begin
      bad++; $display("FAIL reset_flags got=%b exp=00001", {busy, pcross, err, full, empty}); end
  endtask

  task automatic test_inc;
    logic [15:0] exp_pc [4];
    exp_pc = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      cyc(3'd1, 16'h0, 8'h0, 1'b1, 1'b1);
      total++; if (pc !== exp_pc[i] || empty !== 1'b1) begin
        bad++; $display("FAIL inc_%0d pc=%h empty=%b exp=%h empty=1", i, pc, empty, exp_pc[i]); end
    end
  endtask

  task automatic test_carry_ce;
    cyc(3'd2, 16'h12FF, 8'h0, 1'b1, 1'b1);
    cyc(3'd1, 16'h0, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h1300) begin bad++; $display("FAIL inc_carry pc=%h exp=1300", pc); end
    for (int i = 0; i < 3; i++) begin
      cyc(3'd1, 16'h0, 8'h0, 1'b0, 1'b1);
      total++; if (pc !== 16'h1300) begin bad++; $display("FAIL ce_hold_%0d pc=%h exp=1300", i, pc); end
    end
  endtask

  task automatic test_branch;
    cyc(3'd2, 16'h1080, 8'h0, 1'b1, 1'b1);
    cyc(3'd3, 16'h0, 8'h10, 1'b1, 1'b1);
    total++; if (pc !== 16'h1090 || busy !== 1'b0 || pcross !== 1'b0) begin
      bad++; $display("FAIL br_short pc=%h busy=%b px=%b exp=1090 0 0", pc, busy, pcross); end
    cyc(3'd2, 16'h10F0, 8'h0, 1'b1, 1'b1);
    cyc(3'd3, 16'h0, 8'h7F, 1'b1, 1'b1);
    total++; if (pc !== 16'h106F || busy !== 1'b1 || pcross !== 1'b1) begin
      bad++; $display("FAIL br_fwd1 pc=%h busy=%b px=%b exp=106f 1 1", pc, busy, pcross); end
    cyc(3'd0, 16'h0, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h116F || busy !== 1'b0 || pcross !== 1'b0) begin
      bad++; $display("FAIL br_fwd2 pc=%h busy=%b px=%b exp=116f 0 0", pc, busy, pcross); end
    cyc(3'd2, 16'h1005, 8'h0, 1'b1, 1'b1);
    cyc(3'd3, 16'h0, 8'h80, 1'b1, 1'b1);
    total++; if (pc !== 16'h1085 || busy !== 1'b1) begin
      bad++; $display("FAIL br_back1 pc=%h busy=%b exp=1085 1", pc, busy); end
    cyc(3'd0, 16'h0, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h0F85 || busy !== 1'b0) begin
      bad++; $display("FAIL br_back2 pc=%h busy=%b exp=0f85 0", pc, busy); end
  endtask

  task automatic test_fixup_ignore;
    cyc(3'd2, 16'h10F0, 8'h0, 1'b1, 1'b1);
    cyc(3'd3, 16'h0, 8'h20, 1'b1, 1'b1);
    total++; if (pc !== 16'h1010) begin bad++; $display("FAIL fix_first pc=%h exp=1010", pc); end
    cyc(3'd2, 16'h5555, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h1110) begin bad++; $display("FAIL fix_ignore pc=%h exp=1110", pc); end
    cyc(3'd2, 16'h5555, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h5555) begin bad++; $display("FAIL fix_after pc=%h exp=5555", pc); end
  endtask

  task automatic test_stack;
    logic [15:0] ret_pc [4];
    ret_pc = '{16'h2001, 16'h2001, 16'h2001, 16'h0101};
    cyc(3'd2, 16'h0100, 8'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(3'd4, 16'h2000, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h2000 || full !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL call4 pc=%h full=%b err=%b exp=2000 1 0", pc, full, err); end
    cyc(3'd4, 16'h3000, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h3000 || full !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL call_over pc=%h full=%b err=%b exp=3000 1 1", pc, full, err); end
    for (int i = 0; i < 4; i++) begin
      cyc(3'd5, 16'h0, 8'h0, 1'b1, 1'b1);
      total++; if (pc !== ret_pc[i] || err !== 1'b0) begin
        bad++; $display("FAIL ret_%0d pc=%h err=%b exp=%h 0", i, pc, err, ret_pc[i]); end
    end
    cyc(3'd5, 16'h0, 8'h0, 1'b1, 1'b1);
    total++; if (pc !== 16'h0101 || err !== 1'b1 || empty !== 1'b1) begin
      bad++; $display("FAIL ret_under pc=%h err=%b empty=%b exp=0101 1 1", pc, err, empty); end
    cyc(3'd0, 16'h0, 8'h0, 1'b1, 1'b1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pulse err=%b exp=0", err); end
  endtask

  task automatic test_reset_fixup;
    cyc(3'd4, 16'h10F0, 8'h0, 1'b1, 1'b1);
    cyc(3'd3, 16'h0, 8'h20, 1'b1, 1'b1);
    total++; if (busy !== 1'b1 || empty !== 1'b0) begin
      bad++; $display("FAIL pre_reset busy=%b empty=%b exp=1 0", busy, empty); end
    cyc(3'd2, 16'h4444, 8'h0, 1'b1, 1'b0);
    total++; if (pc !== 16'hFFFC || {busy, pcross, err, full, empty} !== 5'b00001) begin
      bad++; $display("FAIL reset_fix pc=%h flags=%b exp=fffc 00001", pc, {busy, pcross, err, full, empty}); end
  endtask

  task automatic test_random;
    logic [2:0]  c;
    logic [15:0] a;
    logic [7:0]  o;
    logic        e;
    model_step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);
    cyc(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      c = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      o = 8'($urandom);
      e = ($urandom_range(0, 3) != 0);
      model_step(c, a, o, e, 1'b1);
      cyc(c, a, o, e, 1'b1);
      total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc_%0d got=%h exp=%h", i, pc, m_pc); end
      total++; if ({busy, pcross, err} !== {m_busy, m_px, m_err}) begin
        bad++; $display("FAIL rnd_flags_%0d got=%b exp=%b", i, {busy, pcross, err}, {m_busy, m_px, m_err}); end
      total++; if (full !== (m_stk.size() == 4) || empty !== (m_stk.size() == 0)) begin
        bad++; $display("FAIL rnd_stack_%0d full=%b empty=%b depth=%0d", i, full, empty, m_stk.size()); end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; cmd = 3'd0; addr = 16'h0; off = 8'h0;
    test_reset();
    test_inc();
    test_carry_ce();
    test_branch();
    test_fixup_ignore();
    test_reset();
    test_stack();
    test_reset_fixup();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
